// File: rtl/key_click_decoder_if.sv
// Bundle of the key-press input and the click event / mode outputs of key_click_decoder.
interface key_click_decoder_if;
  logic       key_flag;
  logic       single_flag;
  logic       double_flag;
  logic       triple_flag;
  logic [1:0] led_mode;
  logic       busy;

  modport master (
    output key_flag,
    input  single_flag,
    input  double_flag,
    input  triple_flag,
    input  led_mode,
    input  busy
  );

  modport slave (
    input  key_flag,
    output single_flag,
    output double_flag,
    output triple_flag,
    output led_mode,
    output busy
  );
endinterface

// File: rtl/key_click_decoder.sv
// Groups debounced key presses into single/double/triple click bursts inside a
// restartable window; each burst yields one event pulse and steps the LED mode.
module key_click_decoder #(
  parameter logic [23:0] CNT_WIN = 24'd14_999_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  key_click_decoder_if.slave bus
);

  localparam int unsigned WIN_W   = 24;
  localparam int unsigned CLICK_W = 2;
  localparam int unsigned MODE_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CLICK_W-1:0] click_cnt_q, click_cnt_d;
  logic [MODE_W-1:0]  led_mode_q, led_mode_d;
  logic               single_q, single_d;
  logic               double_q, double_d;
  logic               triple_q, triple_d;

  logic win_done;
  assign win_done = (win_cnt_q == CNT_WIN);

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      click_cnt_q <= '0;
      led_mode_q  <= '0;
      single_q    <= 1'b0;
      double_q    <= 1'b0;
      triple_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      click_cnt_q <= click_cnt_d;
      led_mode_q  <= led_mode_d;
      single_q    <= single_d;
      double_q    <= double_d;
      triple_q    <= triple_d;
    end
  end

  // Next state: a third press or an expired window closes the burst
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.key_flag) state_d = COUNT;
      end
      COUNT: begin
        if (bus.key_flag) begin
          if (click_cnt_q == CLICK_W'(2)) state_d = IDLE;
        end else if (win_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, event pulses and mode update; a press always beats window expiry
  always_comb begin
    win_cnt_d   = win_cnt_q;
    click_cnt_d = click_cnt_q;
    led_mode_d  = led_mode_q;
    single_d    = 1'b0;
    double_d    = 1'b0;
    triple_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        win_cnt_d   = '0;
        click_cnt_d = bus.key_flag ? CLICK_W'(1) : '0;
      end
      COUNT: begin
        if (bus.key_flag) begin
          win_cnt_d = '0;
          if (click_cnt_q == CLICK_W'(1)) begin
            click_cnt_d = CLICK_W'(2);
          end else begin
            triple_d    = 1'b1;
            led_mode_d  = '0;
            click_cnt_d = '0;
          end
        end else if (win_done) begin
          win_cnt_d   = '0;
          click_cnt_d = '0;
          if (click_cnt_q == CLICK_W'(1)) begin
            single_d   = 1'b1;
            led_mode_d = led_mode_q + MODE_W'(1);
          end else begin
            double_d   = 1'b1;
            led_mode_d = led_mode_q - MODE_W'(1);
          end
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      default: begin
        win_cnt_d   = '0;
        click_cnt_d = '0;
      end
    endcase
  end

  assign bus.single_flag = single_q;
  assign bus.double_flag = double_q;
  assign bus.triple_flag = triple_q;
  assign bus.led_mode    = led_mode_q;
  assign bus.busy        = (state_q == COUNT);

endmodule

// File: doc/key_click_decoder.md
# key_click_decoder

Consumes the one-cycle debounced press pulse `key_flag` from the key debounce stage and classifies bursts of presses as single, double or triple clicks. Presses count as one burst while each follows the previous one within a programmable window. Each classified burst produces one registered event pulse and updates a 2-bit mode register that drives the LED/display logic downstream.

## Interface
- `CNT_WIN`, default `24'd14_999_999`. Last value of the click window counter. Window length is `CNT_WIN+1` cycles (300 ms at 50 MHz).
- `sys_clk`  input  1  system clock; all logic on its rising edge.
- `sys_rst_n`  input  1  reset, asynchronous, active-low.
- `key_flag`  input  1  debounced press pulse, one cycle wide, synchronous to `sys_clk`.
- `single_flag`  output  1  one-cycle pulse: a burst of exactly 1 press was classified.
- `double_flag`  output  1  one-cycle pulse: a burst of exactly 2 presses was classified.
- `triple_flag`  output  1  one-cycle pulse: a burst of 3 presses was classified.
- `led_mode`  output  2  current mode value, registered.
- `busy`  output  1  high while a click window is open (state COUNT).

## Operation
- Internal registers:
  - `state`: IDLE or COUNT.
  - `win_cnt`: 24 bit.
  - `click_cnt`: 2 bit, range 0..3.
- IDLE:
  - `key_flag`=1 → COUNT, `click_cnt`←1, `win_cnt`←0.
  - Otherwise stay; `win_cnt` and `click_cnt` hold 0.
- COUNT, `key_flag`=1 and `click_cnt`=1 → `click_cnt`←2, `win_cnt`←0 (window restarts).
- COUNT, `key_flag`=1 and `click_cnt`=2:
  - `triple_flag`←1, `led_mode`←0.
  - → IDLE, `click_cnt`←0, `win_cnt`←0.
  - The burst ends immediately and does not wait for the window.
- COUNT, `key_flag`=0 and `win_cnt`=`CNT_WIN`:
  - Window expires and the burst ends.
  - `click_cnt`=1: `single_flag`←1, `led_mode`←`led_mode`+1, wrapping 3→0.
  - `click_cnt`=2: `double_flag`←1, `led_mode`←`led_mode`−1, wrapping 0→3.
  - → IDLE, counters cleared.
- COUNT, otherwise: `win_cnt`←`win_cnt`+1.
- Simultaneous `key_flag`=1 and `win_cnt`=`CNT_WIN`: the press wins. It is counted as above and no expiry event is produced.
- `key_flag` in the same cycle an event flag is high (state already IDLE): starts a new burst normally.
- At most one of the three event flags is high in any cycle. Each is high for exactly one cycle, then cleared to 0.
- `led_mode` changes only on the same clock edge that raises an event flag.
- `busy` is registered-equivalent: it equals (`state`==COUNT).
- Width rules:
  - `win_cnt` never exceeds `CNT_WIN`.
  - `led_mode` arithmetic is modulo 4.
  - `click_cnt` never reaches 3 as a stored value.

## Timing
- Reset (asynchronous assert, any time, including mid-window):
  - `state`=IDLE, `win_cnt`=0, `click_cnt`=0.
  - `single_flag`=`double_flag`=`triple_flag`=0, `led_mode`=0, `busy`=0.
  - A burst in progress is discarded; no event follows reset release.
- Press latency: `busy` rises the cycle after the edge that samples the first `key_flag`.
- Single/double latency:
  - Edge E samples the last press of the burst.
  - The flag goes high after edge E+`CNT_WIN`+1, i.e. `CNT_WIN`+1 cycles after E, and `busy` falls at that same edge.
- Triple latency: the flag is high in the cycle immediately after the edge that samples the third `key_flag`.
- Minimum spacing between bursts: none. A press is accepted in any cycle the block is IDLE.

## Test plan
Simulate with `CNT_WIN`=9.
- **Single press:** reset, one `key_flag` pulse at edge 0 → `busy` high edges 1–10. `single_flag` high for one cycle after edge 10. `led_mode` 0→1.
- **Double press with wrap:** from `led_mode`=0, pulses at edges 0 and 5 → `double_flag` high after edge 15 only. `led_mode` 0→3. No `single_flag`.
- **Triple press:** pulses at edges 0, 3, 6 → `triple_flag` high after edge 6. `busy` low after edge 6. `led_mode`=0.
- **Window boundary:**
  - Pulse at edge 0, second pulse at edge 10 (same edge `win_cnt`=9) → counted. `double_flag` after edge 20.
  - Second pulse at edge 11 instead → `single_flag` after edge 10, then a new burst starting at edge 11.
- **Mode wrap:** four isolated single presses, each 20 cycles apart → `led_mode` 1, 2, 3, 0.
- **Reset mid-burst:** pulse at edge 0, assert `sys_rst_n`=0 at cycle 4, release at cycle 6 → all outputs 0 immediately. No event flag within 30 cycles after release.
